// File: rtl/auth_pkg.sv
// Shared types and width helpers for the authentication sequencer.
package auth_pkg;

    typedef enum logic [2:0] {IDLE, GEN, ENTRY, CHECK, PASS, LOCK} state_t;

    localparam int DIG_W_DEF     = 4;
    localparam int DIGITS_DEF    = 4;
    localparam int MAX_TRIES_DEF = 3;

    // Bits needed to hold 0..maxval (digit_idx, tries_left, shared timer).
    function automatic int width_for(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/auth_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one raw pin.
module auth_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [2:0] sh;

    // sh[1:0] synchronise the pin, sh[2] remembers the previous synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh <= '0;
        else        sh <= {sh[1:0], raw};
    end

    assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/auth_sequencer.sv
// One-time-code sequencer: pulls a code from the LFSR, checks keyed digits,
// and enforces the retry budget, entry timeout and lockout period.
module auth_sequencer
    import auth_pkg::*;
#(
    parameter int DIGITS      = DIGITS_DEF,
    parameter int DIG_W       = DIG_W_DEF,
    parameter int MAX_TRIES   = MAX_TRIES_DEF,
    parameter int TIMEOUT_CYC = 2**20,
    parameter int LOCK_CYC    = 2**22,
    localparam int IDX_W      = width_for(DIGITS),
    localparam int TRIES_W    = width_for(MAX_TRIES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    user_latch,
    input  logic [DIG_W-1:0]        user_digit,
    input  logic [DIG_W-1:0]        lfsr_digit,
    output logic                    lfsr_step,
    output logic [DIGITS*DIG_W-1:0] otp_code,
    output logic                    otp_valid,
    output logic [IDX_W-1:0]        digit_idx,
    output logic [TRIES_W-1:0]      tries_left,
    output logic                    pass,
    output logic                    fail,
    output logic                    locked,
    output logic                    busy
);

    // One register serves as GEN slot counter, ENTRY timeout and LOCK timer.
    localparam int TMAX   = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
    localparam int CNT_MX = (TMAX > DIGITS) ? TMAX : DIGITS;
    localparam int CNT_W  = width_for(CNT_MX);

    state_t                         state, state_n;
    logic [DIGITS-1:0][DIG_W-1:0]   code_q, code_n;
    logic [IDX_W-1:0]               idx_q, idx_n;
    logic [TRIES_W-1:0]             tries_q, tries_n;
    logic [CNT_W-1:0]               cnt_q, cnt_n;
    logic                           mism_q, mism_n;
    logic                           valid_q, valid_n;
    logic                           start_evt, latch_evt;
    logic [DIG_W-1:0]               cur_slot;

    auth_edge_sync u_start_sync (.clk(clk), .rst_n(rst_n), .raw(start),      .pulse(start_evt));
    auth_edge_sync u_latch_sync (.clk(clk), .rst_n(rst_n), .raw(user_latch), .pulse(latch_evt));

    // Register all sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            tries_q <= TRIES_W'(MAX_TRIES);
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            idx_q   <= idx_n;
            tries_q <= tries_n;
            cnt_q   <= cnt_n;
            mism_q  <= mism_n;
            valid_q <= valid_n;
        end
    end

    // Stored digit the next keyed digit is compared against.
    always_comb begin
        cur_slot = '0;
        for (int k = 0; k < DIGITS; k++)
            if (idx_q == IDX_W'(k)) cur_slot = code_q[k];
    end

    // Next-state logic; edges not legal in the current state fall through unused.
    always_comb begin
        state_n = state;
        code_n  = code_q;
        idx_n   = idx_q;
        tries_n = tries_q;
        cnt_n   = cnt_q;
        mism_n  = mism_q;
        valid_n = valid_q;
        case (state)
            IDLE, PASS: begin
                if (start_evt) begin
                    state_n = GEN;
                    cnt_n   = '0;
                    idx_n   = '0;
                    valid_n = 1'b0;
                end
            end
            GEN: begin
                for (int k = 0; k < DIGITS; k++)
                    if (cnt_q == CNT_W'(k)) code_n[k] = lfsr_digit;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    state_n = ENTRY;
                    valid_n = 1'b1;
                    idx_n   = '0;
                    mism_n  = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ENTRY: begin
                if (latch_evt) begin
                    mism_n = mism_q | (user_digit != cur_slot);
                    idx_n  = idx_q + IDX_W'(1);
                    cnt_n  = '0;
                    if (idx_q == IDX_W'(DIGITS - 1)) state_n = CHECK;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_n = CHECK;
                    mism_n  = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (!mism_q) begin
                    state_n = PASS;
                    tries_n = TRIES_W'(MAX_TRIES);
                end else if (tries_q <= TRIES_W'(1)) begin
                    state_n = LOCK;
                    tries_n = '0;
                    valid_n = 1'b0;
                    code_n  = '0;
                    cnt_n   = '0;
                end else begin
                    state_n = ENTRY;
                    tries_n = tries_q - TRIES_W'(1);
                    idx_n   = '0;
                    mism_n  = 1'b0;
                    cnt_n   = '0;
                end
            end
            LOCK: begin
                if (cnt_q == CNT_W'(LOCK_CYC - 1)) begin
                    state_n = IDLE;
                    tries_n = TRIES_W'(MAX_TRIES);
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign lfsr_step  = (state == GEN);
    assign otp_code   = code_q;
    assign otp_valid  = valid_q;
    assign digit_idx  = idx_q;
    assign tries_left = tries_q;
    assign pass       = (state == PASS);
    assign fail       = (state == CHECK) && mism_q;
    assign locked     = (state == LOCK);
    assign busy       = (state == GEN) || (state == ENTRY) || (state == CHECK);

endmodule
